// File: rtl/pipe_pkg.sv
// Shared fetch/decode pipeline types and constants.
// Imported by if_id_buffer and if_id_entry_mem.
package pipe_pkg;

    localparam int XLEN_DEF = 32;
    localparam int PC_STEP_DEF = 4;
    localparam logic [31:0] NOP_INSTR = 32'h00000000;

    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [XLEN_DEF-1:0] instr;
    } if_id_entry_t;

endpackage

// File: rtl/if_id_entry_mem.sv
// Two-entry register array holding {pc, instr} pairs.
// One write port, asynchronous read; reset clears every entry.
module if_id_entry_mem
    import pipe_pkg::*;
#(
    parameter int W = $bits(if_id_entry_t)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         we,
    input  logic         waddr,
    input  logic [W-1:0] wdata,
    input  logic         raddr,
    output logic [W-1:0] rdata
);

    logic [W-1:0] mem [2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_buffer.sv
// IF/ID in-order skid buffer: two entries, flush kills all, stall holds head.
// Optional IFID_PERF_CNT_EN adds saturating stall/flush counters.
module if_id_buffer
    import pipe_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int XLEN    = XLEN_DEF,
    parameter int PC_STEP = PC_STEP_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_instr,
    output logic            in_ready,
    input  logic            flush,
    input  logic            hazard_stall,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pc_plus4,
    output logic [XLEN-1:0] out_instr
`ifdef IFID_PERF_CNT_EN
    ,
    output logic [31:0]     stall_cnt,
    output logic [31:0]     flush_cnt
`endif
);

    if (DEPTH != 2) begin : g_bad_depth
        $error("if_id_buffer: DEPTH must be 2");
    end

    localparam int EW = 2 * XLEN;

    logic          rd_ptr;
    logic          wr_ptr;
    logic [1:0]    count;
    logic          push;
    logic          pop;
    logic [EW-1:0] head;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & ~hazard_stall & ~flush;

    if_id_entry_mem #(
        .W(EW)
    ) u_mem (
        .clk  (clk),
        .rst  (rst),
        .we   (push),
        .waddr(wr_ptr),
        .wdata({in_pc, in_instr}),
        .raddr(rd_ptr),
        .rdata(head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            unique case (1'b1)
                (push & ~pop): count <= count + 2'd1;
                (pop & ~push): count <= count - 2'd1;
                default:       count <= count;
            endcase
        end
    end

    // Storage is not wiped on flush, so only the instruction is masked.
    assign out_pc       = head[EW-1:XLEN];
    assign out_pc_plus4 = out_pc + XLEN'(PC_STEP);
    assign out_instr    = out_valid ? head[XLEN-1:0] : XLEN'(NOP_INSTR);

`ifdef IFID_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (out_valid & hazard_stall & ~&stall_cnt)
                stall_cnt <= stall_cnt + 32'd1;
            if (flush & (out_valid | in_valid) & ~&flush_cnt)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed test of if_id_buffer: streaming, stall fill, flush, async reset, wrap.
module tb_if_id_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        flush;
    logic        hazard_stall;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic [31:0] out_instr;
`ifdef IFID_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] IA = 32'hA0A0_0013;
    localparam logic [31:0] IB = 32'hB0B0_0093;
    localparam logic [31:0] IC = 32'hC0C0_0113;
    localparam logic [31:0] ID = 32'hD0D0_0193;
    localparam logic [31:0] IE = 32'hE0E0_0213;

    always #5 clk = ~clk;

    if_id_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_pc       (in_pc),
        .in_instr    (in_instr),
        .in_ready    (in_ready),
        .flush       (flush),
        .hazard_stall(hazard_stall),
        .out_valid   (out_valid),
        .out_pc      (out_pc),
        .out_pc_plus4(out_pc_plus4),
        .out_instr   (out_instr)
`ifdef IFID_PERF_CNT_EN
        ,
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc,
                         input logic [31:0] ins);
        in_valid = v;
        in_pc    = pc;
        in_instr = ins;
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        hazard_stall = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_pc_plus4", out_pc_plus4, 32'h4);

        // Streaming: one in, one out per cycle
        drive(1'b1, 32'h0, IA);
        step();
        chk("str_a_valid", 32'(out_valid), 32'd1);
        chk("str_a_instr", out_instr, IA);
        chk("str_a_ready", 32'(in_ready), 32'd1);
        drive(1'b1, 32'h4, IB);
        step();
        chk("str_b_instr", out_instr, IB);
        chk("str_b_pc4", out_pc_plus4, 32'h8);
        chk("str_b_ready", 32'(in_ready), 32'd1);
        drive(1'b1, 32'h8, IC);
        step();
        chk("str_c_instr", out_instr, IC);
        chk("str_c_pc", out_pc, 32'h8);
        drive(1'b0, 32'h0, 32'h0);
        step();
        chk("str_empty_valid", 32'(out_valid), 32'd0);
        chk("str_empty_nop", out_instr, 32'h0);

        // Fill under stall
        hazard_stall = 1'b1;
        drive(1'b1, 32'h0, IA);
        step();
        chk("fill_1_instr", out_instr, IA);
        chk("fill_1_ready", 32'(in_ready), 32'd1);
        drive(1'b1, 32'h4, IB);
        step();
        chk("fill_2_ready", 32'(in_ready), 32'd0);
        chk("fill_2_instr", out_instr, IA);
        drive(1'b1, 32'h8, IC);
        step();
        chk("fill_3_ready", 32'(in_ready), 32'd0);
        chk("fill_3_instr", out_instr, IA);
        chk("fill_3_pc", out_pc, 32'h0);
        hazard_stall = 1'b0;
        step();
        chk("drain_b_instr", out_instr, IB);
        chk("drain_b_ready", 32'(in_ready), 32'd1);
        step();
        chk("drain_c_instr", out_instr, IC);
        chk("drain_c_pc", out_pc, 32'h8);
        drive(1'b0, 32'h0, 32'h0);
        step();
        chk("drain_empty", 32'(out_valid), 32'd0);

        // Flush with simultaneous push
        hazard_stall = 1'b1;
        drive(1'b1, 32'h0, IA);
        step();
        drive(1'b1, 32'h4, IB);
        step();
        chk("fl_full_ready", 32'(in_ready), 32'd0);
        hazard_stall = 1'b0;
        flush = 1'b1;
        drive(1'b1, 32'h8, IC);
        step();
        flush = 1'b0;
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_ready", 32'(in_ready), 32'd1);
        chk("fl_nop", out_instr, 32'h0);
        drive(1'b1, 32'h40, ID);
        step();
        chk("fl_d_valid", 32'(out_valid), 32'd1);
        chk("fl_d_pc", out_pc, 32'h40);
        chk("fl_d_instr", out_instr, ID);
        chk("fl_d_pc4", out_pc_plus4, 32'h44);
        drive(1'b0, 32'h0, 32'h0);
        step();
        chk("fl_d_drained", 32'(out_valid), 32'd0);

        // Asynchronous reset between edges
        hazard_stall = 1'b1;
        drive(1'b1, 32'h0, IA);
        step();
        drive(1'b1, 32'h4, IB);
        step();
        drive(1'b0, 32'h0, 32'h0);
        chk("ar_pre_ready", 32'(in_ready), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_ready", 32'(in_ready), 32'd1);
        chk("ar_pc", out_pc, 32'h0);
        chk("ar_pc4", out_pc_plus4, 32'h4);
        chk("ar_nop", out_instr, 32'h0);
        hazard_stall = 1'b0;
        step();
        rst = 1'b0;

        // PC wrap on pc_plus4
        drive(1'b1, 32'hFFFF_FFFC, IE);
        step();
        chk("wrap_pc", out_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", out_pc_plus4, 32'h0);
        drive(1'b0, 32'h0, 32'h0);
        step();
        chk("wrap_drained", 32'(out_valid), 32'd0);

`ifdef IFID_PERF_CNT_EN
        hazard_stall = 1'b1;
        drive(1'b1, 32'h0, IA);
        step();
        drive(1'b0, 32'h0, 32'h0);
        repeat (3) step();
        hazard_stall = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("perf_stall", stall_cnt, 32'd3);
        chk("perf_flush", flush_cnt, 32'd1);
        chk("perf_empty", 32'(out_valid), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
